// File: rtl/rnd_buffer_pkg.sv
// Shared types and width helpers for the PRNG randomness buffer.
package rnd_buffer_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RUN
    } state_e;

    // Counters that hold 0..n-1 still need one bit when n is 1 or 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int slot_w(input int ratio);
        return clog2_min1(ratio);
    endfunction

    function automatic int cnt_w(input int period);
        return clog2_min1(period);
    endfunction

endpackage

// File: rtl/rnd_buffer_fifo.sv
// Small power-of-two FIFO of mask words with synchronous flush.
module rnd_buffer_fifo import rnd_buffer_pkg::*; #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      empty,
    output logic                      full,
    output logic [lvl_w(DEPTH)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wptr, rptr;
    logic [LW-1:0]           cnt;
    logic                    do_push, do_pop;

    // A flush voids any push or pop issued in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            cnt <= cnt + LW'(do_push) - LW'(do_pop);
        end
    end

    assign dout  = mem[rptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == LW'(DEPTH));
    assign level = cnt;

endmodule

// File: rtl/rnd_buffer.sv
// Gathers narrow PRNG chunks into wide mask words, buffers them and owns reseeding.
// Optional RND_BUFFER_STATS_EN adds a saturating consumer-starvation counter.
module rnd_buffer import rnd_buffer_pkg::*; #(
    parameter int RND_IN        = 32,
    parameter int RATIO         = 4,
    parameter int DEPTH         = 4,
    parameter int RESEED_PERIOD = 1024
) (
`ifdef RND_BUFFER_STATS_EN
    output logic [15:0]                starve_cnt,
`endif
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RND_IN-1:0]          in_rnd,
    input  logic                       prng_busy,
    output logic                       reseed_req,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RND_IN*RATIO-1:0]    out_rnd,
    output logic [lvl_w(DEPTH)-1:0]    level
);

    localparam int W  = RND_IN * RATIO;
    localparam int SW = slot_w(RATIO);
    localparam int CW = cnt_w(RESEED_PERIOD);

    state_e                        state;
    logic [SW-1:0]                 slot;
    logic [CW-1:0]                 rcnt;
    logic                          pend;
    logic                          last, acc, push, pop, reach, take;
    logic                          empty, full;
    logic [RATIO-1:0][RND_IN-1:0]  word;

    assign last     = (slot == SW'(RATIO - 1));
    assign in_ready = (state == ST_RUN) && !(last && full);
    assign acc      = in_valid && in_ready;
    assign push     = acc && last && !flush;
    assign out_valid = !empty;
    assign pop      = out_valid && out_ready && !flush;
    assign reach    = pop && (rcnt == CW'(RESEED_PERIOD - 1));
    assign take     = (state == ST_RUN) && pend;

    // Earlier chunks are held per lane; the last chunk bypasses straight into the push.
    for (genvar g = 0; g < RATIO - 1; g++) begin : g_lane
        logic [RND_IN-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (acc && slot == SW'(g))
                q <= in_rnd;
        end
        assign word[g] = q;
    end
    assign word[RATIO-1] = in_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            reseed_req <= 1'b0;
            slot       <= '0;
            rcnt       <= '0;
            pend       <= 1'b0;
        end else begin
            reseed_req <= 1'b0;

            if (flush)
                slot <= '0;
            else if (acc)
                slot <= last ? '0 : slot + 1'b1;

            // The period counter runs in every state so old-seed drains still count.
            if (pop)
                rcnt <= reach ? '0 : rcnt + 1'b1;
            pend <= (pend && !take) || reach;

            unique case (state)
                ST_BOOT: begin
                    state      <= ST_REQ;
                    reseed_req <= 1'b1;
                end
                ST_REQ: begin
                    slot  <= '0;
                    state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: if (prng_busy)  state <= ST_WAIT_LO;
                ST_WAIT_LO: if (!prng_busy) state <= ST_RUN;
                ST_RUN: begin
                    if (pend) begin
                        state      <= ST_REQ;
                        reseed_req <= 1'b1;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    rnd_buffer_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (out_valid && out_ready),
        .flush (flush),
        .din   (word),
        .dout  (out_rnd),
        .empty (empty),
        .full  (full),
        .level (level)
    );

`ifdef RND_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (out_ready && !out_valid && starve_cnt != 16'hFFFF)
            starve_cnt <= starve_cnt + 16'd1;
    end
`endif

endmodule
